// File: rtl/demux_1to3_buf.sv
// Routes each accepted word to one of three independently buffered output ports.
// Latency: 1 cycle from acceptance to outN_valid; 2 words of buffering per port.
// Backpressure: in_ready drops only when the selected port's buffer is full (registered state).
//
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   in_valid/in_ready        input handshake; in_sel picks port 1..3 (11 = illegal, discarded)
//   in_data                  offered word
//   outN_valid/outN_ready    per-port output handshake, N = 1..3
//   outN_data                head word of port N, forced to 0 while outN_valid = 0
//   err_pulse                one-cycle flag after an illegal-select word was discarded
//   err_cnt                  saturating count of discarded illegal-select words

// Two-entry FIFO used once per output port.
// Latency: 1 cycle from push to pop_vld; simultaneous push/pop allowed at occupancy 1.
// Backpressure: full is derived from registered occupancy only; pop with nothing stored is ignored.
//
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   push_vld/push_dat        write request and data (ignored when full)
//   pop_rdy                  consumer takes the head word this cycle
//   pop_vld/pop_dat          head word present / head word (0 when empty)
//   full                     two words stored
module demux_1to3_buf_fifo #(
    parameter int W = 128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    input  logic         pop_rdy,
    output logic         pop_vld,
    output logic [W-1:0] pop_dat,
    output logic         full
);

    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         rd_ptr_q, rd_ptr_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         do_push;
    logic         do_pop;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;

        // Guards keep the FIFO consistent even if a caller misbehaves.
        do_push = push_vld && (cnt_q != 2'd2);
        do_pop  = pop_rdy  && (cnt_q != 2'd0);

        if (do_push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        // Push and pop together leave occupancy unchanged.
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: its contents are never visible while empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign pop_vld = (cnt_q != 2'd0);
    assign pop_dat = pop_vld ? mem_q[rd_ptr_q] : '0;
    assign full    = (cnt_q == 2'd2);

endmodule

module demux_1to3_buf #(
    parameter int dataWidth = 128,
    parameter int ERR_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_sel,
    input  logic [dataWidth-1:0] in_data,
    output logic                 out1_valid,
    input  logic                 out1_ready,
    output logic [dataWidth-1:0] out1_data,
    output logic                 out2_valid,
    input  logic                 out2_ready,
    output logic [dataWidth-1:0] out2_data,
    output logic                 out3_valid,
    input  logic                 out3_ready,
    output logic [dataWidth-1:0] out3_data,
    output logic                 err_pulse,
    output logic [ERR_W-1:0]     err_cnt
);

    localparam logic [1:0] SEL_P1  = 2'b00;
    localparam logic [1:0] SEL_P2  = 2'b01;
    localparam logic [1:0] SEL_P3  = 2'b10;
    localparam logic [1:0] SEL_ILL = 2'b11;

    logic [2:0]       full;
    logic [2:0]       push_vld;
    logic             sel_rdy;
    logic             accept;
    logic             err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    // in_ready depends only on in_sel, rst and registered occupancy, so no
    // path exists from any outN_ready; a port that is draining this cycle
    // still reports full until the next edge.
    always_comb begin
        sel_rdy = 1'b0;
        case (in_sel)
            SEL_P1:  sel_rdy = !full[0];
            SEL_P2:  sel_rdy = !full[1];
            SEL_P3:  sel_rdy = !full[2];
            SEL_ILL: sel_rdy = 1'b1;
            default: sel_rdy = 1'b0;
        endcase
    end

    assign in_ready = !rst && sel_rdy;
    assign accept   = in_valid && in_ready;

    always_comb begin
        push_vld    = 3'b000;
        err_pulse_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        if (accept) begin
            case (in_sel)
                SEL_P1:  push_vld = 3'b001;
                SEL_P2:  push_vld = 3'b010;
                SEL_P3:  push_vld = 3'b100;
                default: begin
                    err_pulse_d = 1'b1;
                    if (err_cnt_q != {ERR_W{1'b1}}) begin
                        err_cnt_d = err_cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;

    demux_1to3_buf_fifo #(.W(dataWidth)) u_fifo1 (
        .clk      (clk),
        .rst      (rst),
        .push_vld (push_vld[0]),
        .push_dat (in_data),
        .pop_rdy  (out1_ready),
        .pop_vld  (out1_valid),
        .pop_dat  (out1_data),
        .full     (full[0])
    );

    demux_1to3_buf_fifo #(.W(dataWidth)) u_fifo2 (
        .clk      (clk),
        .rst      (rst),
        .push_vld (push_vld[1]),
        .push_dat (in_data),
        .pop_rdy  (out2_ready),
        .pop_vld  (out2_valid),
        .pop_dat  (out2_data),
        .full     (full[1])
    );

    demux_1to3_buf_fifo #(.W(dataWidth)) u_fifo3 (
        .clk      (clk),
        .rst      (rst),
        .push_vld (push_vld[2]),
        .push_dat (in_data),
        .pop_rdy  (out3_ready),
        .pop_vld  (out3_valid),
        .pop_dat  (out3_data),
        .full     (full[2])
    );

endmodule

// File: tb/tb_demux_1to3_buf.sv
// Testbench for demux_1to3_buf: directed scenarios followed by random traffic.
// Latency: checks one-cycle acceptance-to-output latency through the reference queues.
// Backpressure: drives random output stalls; expected in_ready comes from reference occupancy.
module tb_demux_1to3_buf;

    localparam int W = 128;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [1:0]   in_sel = 2'b00;
    logic [W-1:0] in_data = '0;
    logic [2:0]   out_rdy = 3'b000;

    logic         a_in_rdy, b_in_rdy;
    logic [2:0]   a_vld, b_vld;
    logic [W-1:0] a_dat [3];
    logic [W-1:0] b_dat [3];
    logic         a_err_p, b_err_p;
    logic [7:0]   a_err_c;
    logic [1:0]   b_err_c;

    demux_1to3_buf #(.dataWidth(W), .ERR_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(a_in_rdy), .in_sel(in_sel), .in_data(in_data),
        .out1_valid(a_vld[0]), .out1_ready(out_rdy[0]), .out1_data(a_dat[0]),
        .out2_valid(a_vld[1]), .out2_ready(out_rdy[1]), .out2_data(a_dat[1]),
        .out3_valid(a_vld[2]), .out3_ready(out_rdy[2]), .out3_data(a_dat[2]),
        .err_pulse(a_err_p), .err_cnt(a_err_c)
    );

    // Same traffic into a narrow-counter instance to observe saturation at 3.
    demux_1to3_buf #(.dataWidth(W), .ERR_W(2)) dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(b_in_rdy), .in_sel(in_sel), .in_data(in_data),
        .out1_valid(b_vld[0]), .out1_ready(out_rdy[0]), .out1_data(b_dat[0]),
        .out2_valid(b_vld[1]), .out2_ready(out_rdy[1]), .out2_data(b_dat[1]),
        .out3_valid(b_vld[2]), .out3_ready(out_rdy[2]), .out3_data(b_dat[2]),
        .err_pulse(b_err_p), .err_cnt(b_err_c)
    );

    always #5 clk = ~clk;

    // Reference model: one queue of pending words per port plus error state.
    logic [W-1:0] mq [3][$];
    int           err_m  = 0;
    int           err2_m = 0;
    bit           err_pend = 1'b0;
    bit           chk_en = 1'b0;
    int           total = 0;
    int           bad = 0;

    task automatic chk(input bit ok, input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Monitor: sample mid-cycle, compare against the model, then advance the
    // model by the handshakes that will happen at the coming rising edge.
    always @(negedge clk) begin
        if (chk_en) begin
            bit exp_rdy;
            bit acc;
            for (int p = 0; p < 3; p++) begin
                bit ev;
                ev = (mq[p].size() != 0);
                chk(a_vld[p] == ev, $sformatf("out%0d_valid", p + 1), W'(a_vld[p]), W'(ev));
                chk(b_vld[p] == ev, $sformatf("n_out%0d_valid", p + 1), W'(b_vld[p]), W'(ev));
                if (ev) begin
                    chk(a_dat[p] == mq[p][0], $sformatf("out%0d_data", p + 1), a_dat[p], mq[p][0]);
                    chk(b_dat[p] == mq[p][0], $sformatf("n_out%0d_data", p + 1), b_dat[p], mq[p][0]);
                end else begin
                    chk(a_dat[p] == '0, $sformatf("out%0d_data_idle", p + 1), a_dat[p], '0);
                    chk(b_dat[p] == '0, $sformatf("n_out%0d_data_idle", p + 1), b_dat[p], '0);
                end
            end

            if (rst)                 exp_rdy = 1'b0;
            else if (in_sel == 2'b11) exp_rdy = 1'b1;
            else                     exp_rdy = (mq[in_sel].size() < 2);
            chk(a_in_rdy == exp_rdy, "in_ready", W'(a_in_rdy), W'(exp_rdy));
            chk(b_in_rdy == exp_rdy, "n_in_ready", W'(b_in_rdy), W'(exp_rdy));
            chk(a_err_p == err_pend, "err_pulse", W'(a_err_p), W'(err_pend));
            chk(b_err_p == err_pend, "n_err_pulse", W'(b_err_p), W'(err_pend));
            chk(int'(a_err_c) == err_m, "err_cnt", W'(a_err_c), W'(err_m));
            chk(int'(b_err_c) == err2_m, "n_err_cnt_sat", W'(b_err_c), W'(err2_m));

            if (rst) begin
                for (int p = 0; p < 3; p++) mq[p].delete();
                err_m    = 0;
                err2_m   = 0;
                err_pend = 1'b0;
            end else begin
                for (int p = 0; p < 3; p++) begin
                    if (out_rdy[p] && mq[p].size() != 0) void'(mq[p].pop_front());
                end
                acc      = in_valid && exp_rdy;
                err_pend = acc && (in_sel == 2'b11);
                if (acc) begin
                    if (in_sel == 2'b11) begin
                        if (err_m < 255) err_m++;
                        if (err2_m < 3) err2_m++;
                    end else begin
                        mq[in_sel].push_back(in_data);
                    end
                end
            end
        end
    end

    // Offer one word and hold it until accepted; called at posedge+1.
    task automatic send(input logic [1:0] s, input logic [W-1:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_sel   = s;
        in_data  = d;
        @(negedge clk);
        while (!a_in_rdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!a_in_rdy) begin
            total++;
            bad++;
            $display("FAIL send_timeout sel=%0d: got in_ready=0 expected acceptance within 50 cycles", s);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        idle(1);
        rst     = 1'b0;
        out_rdy = 3'b111;

        // Routing to each port with consumers ready.
        send(2'b00, 128'hA);
        send(2'b01, 128'hB);
        send(2'b10, 128'hC);
        idle(3);

        // Port 2 stalled: two words fit, the third is refused.
        out_rdy = 3'b101;
        send(2'b01, 128'hD0);
        send(2'b01, 128'hD1);
        in_valid = 1'b1;
        in_sel   = 2'b01;
        in_data  = 128'hD2;
        idle(3);
        in_valid = 1'b0;

        // Port 1 still accepts while port 2 is full and stalled.
        send(2'b00, 128'hE);
        idle(2);
        out_rdy[1] = 1'b1;
        send(2'b01, 128'hD2);
        idle(4);

        // Push and pop together on port 3 at occupancy 1.
        out_rdy = 3'b011;
        send(2'b10, 128'hF0);
        out_rdy = 3'b111;
        send(2'b10, 128'hF1);
        idle(3);

        // Illegal selects: 3 words, then 5 more to saturate the narrow counter.
        repeat (3) send(2'b11, rnd_word());
        idle(2);
        repeat (5) send(2'b11, rnd_word());
        idle(2);

        // Reset mid-operation with buffered words and a word offered in the reset cycle.
        out_rdy = 3'b000;
        send(2'b00, rnd_word());
        send(2'b00, rnd_word());
        send(2'b01, rnd_word());
        send(2'b01, rnd_word());
        send(2'b11, rnd_word());
        rst      = 1'b1;
        in_valid = 1'b1;
        in_sel   = 2'b10;
        in_data  = rnd_word();
        idle(1);
        rst      = 1'b0;
        in_valid = 1'b0;
        out_rdy  = 3'b111;
        send(2'b10, 128'h1234);
        idle(3);

        // Random traffic with occasional resets.
        repeat (3000) begin
            rst      = ($urandom_range(0, 199) == 0);
            in_valid = $urandom_range(0, 3) != 0;
            in_sel   = 2'($urandom_range(0, 3));
            in_data  = rnd_word();
            out_rdy  = 3'($urandom_range(0, 7));
            idle(1);
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        out_rdy  = 3'b111;
        idle(4);
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
